// File: rtl/credit_retry_buffer.sv
// Credit/retry ingress buffer: show-ahead data FIFO with slot reservation for
// retried requesters, a retry-ID queue and a saturating stall counter.
`timescale 1ns/1ps
module credit_retry_buffer #(
    parameter int DATA_W    = 5,
    parameter int ID_W      = 3,
    parameter int DEPTH     = 4,
    parameter int RQ_DEPTH  = 2,
    parameter int RETRY_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid_i,
    input  logic [ID_W-1:0]   rx_id_i,
    input  logic [DATA_W-1:0] rx_payload_i,
    input  logic              rx_credit_i,
    output logic              rx_ready_o,
    output logic              rx_retry_o,
    output logic              tx_valid_o,
    output logic [ID_W-1:0]   tx_id_o,
    output logic [DATA_W-1:0] tx_payload_o,
    input  logic              tx_ready_i,
    output logic              credit_gnt_o,
    output logic [ID_W-1:0]   credit_id_o,
    output logic              err_o
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RAW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RCW = $clog2(RQ_DEPTH + 1);
    localparam int SW  = $clog2(RETRY_CYC + 1);

    localparam logic [CW:0]    DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [RCW-1:0] RQ_FULL  = RCW'(RQ_DEPTH);
    localparam logic [SW-1:0]  STL_MAX  = SW'(RETRY_CYC);
    localparam logic [AW-1:0]  PTR_LAST = AW'(DEPTH - 1);
    localparam logic [RAW-1:0] RQ_LAST  = RAW'(RQ_DEPTH - 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] payload;
    } beat_t;

    beat_t           fifo_mem_q [DEPTH];
    logic [ID_W-1:0] rq_mem_q   [RQ_DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RAW-1:0] rq_wr_ptr_q, rq_wr_ptr_d, rq_rd_ptr_q, rq_rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d, rsv_q, rsv_d;
    logic [RCW-1:0] rq_cnt_q, rq_cnt_d;
    logic [SW-1:0]  stl_q, stl_d;
    logic           err_q, err_d;

    logic  slot_free, rq_empty, rq_full;
    logic  unc_acc, cr_acc, cr_err, push, pop, stall;
    beat_t head;

    // A slot is free only if neither buffered beats nor outstanding credits claim it.
    assign slot_free = ({1'b0, cnt_q} + {1'b0, rsv_q}) < DEPTH_C;
    assign rq_empty  = (rq_cnt_q == '0);
    assign rq_full   = (rq_cnt_q == RQ_FULL);

    assign rx_ready_o   = slot_free && rq_empty;
    assign unc_acc      = rx_valid_i && !rx_credit_i && rx_ready_o;
    assign cr_acc       = rx_valid_i && rx_credit_i && (rsv_q != '0);
    assign cr_err       = rx_valid_i && rx_credit_i && (rsv_q == '0);
    assign push         = unc_acc || cr_acc;
    assign stall        = rx_valid_i && !rx_credit_i && !rx_ready_o;
    assign rx_retry_o   = stall && (stl_q == STL_MAX) && !rq_full;
    assign credit_gnt_o = !rq_empty && slot_free;
    assign credit_id_o  = credit_gnt_o ? rq_mem_q[rq_rd_ptr_q] : '0;

    assign tx_valid_o   = (cnt_q != '0);
    assign pop          = tx_valid_o && tx_ready_i;
    assign head         = fifo_mem_q[rd_ptr_q];
    assign tx_id_o      = tx_valid_o ? head.id : '0;
    assign tx_payload_o = tx_valid_o ? head.payload : '0;
    assign err_o        = err_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rq_wr_ptr_d = rq_wr_ptr_q;
        rq_rd_ptr_d = rq_rd_ptr_q;
        cnt_d       = cnt_q;
        rsv_d       = rsv_q;
        rq_cnt_d    = rq_cnt_q;
        stl_d       = stl_q;
        err_d       = err_q || cr_err;

        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;

        if (credit_gnt_o && !cr_acc)      rsv_d = rsv_q + 1'b1;
        else if (!credit_gnt_o && cr_acc) rsv_d = rsv_q - 1'b1;

        if (rx_retry_o)   rq_wr_ptr_d = (rq_wr_ptr_q == RQ_LAST) ? '0 : rq_wr_ptr_q + 1'b1;
        if (credit_gnt_o) rq_rd_ptr_d = (rq_rd_ptr_q == RQ_LAST) ? '0 : rq_rd_ptr_q + 1'b1;
        if (rx_retry_o && !credit_gnt_o)      rq_cnt_d = rq_cnt_q + 1'b1;
        else if (!rx_retry_o && credit_gnt_o) rq_cnt_d = rq_cnt_q - 1'b1;

        // A credited beat with no reservation leaves the stall count untouched.
        if (!rx_valid_i || push || rx_retry_o) stl_d = '0;
        else if (stall && stl_q != STL_MAX)    stl_d = stl_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rq_wr_ptr_q <= '0;
            rq_rd_ptr_q <= '0;
            cnt_q       <= '0;
            rsv_q       <= '0;
            rq_cnt_q    <= '0;
            stl_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rq_wr_ptr_q <= rq_wr_ptr_d;
            rq_rd_ptr_q <= rq_rd_ptr_d;
            cnt_q       <= cnt_d;
            rsv_q       <= rsv_d;
            rq_cnt_q    <= rq_cnt_d;
            stl_q       <= stl_d;
            err_q       <= err_d;
        end
    end

    // NOTE: storage arrays carry no reset; empty counts and output gating keep
    // stale contents invisible, so reset only touches pointers and counters.
    always_ff @(posedge clk) begin
        if (push)       fifo_mem_q[wr_ptr_q] <= '{id: rx_id_i, payload: rx_payload_i};
        if (rx_retry_o) rq_mem_q[rq_wr_ptr_q] <= rx_id_i;
    end

endmodule

// File: tb/tb_credit_retry_buffer.sv
// Bench for credit_retry_buffer: table-driven cycle vectors with a beat
// scoreboard for the TX side, plus a hand-written mid-stream reset sequence.
`timescale 1ns/1ps
module tb_credit_retry_buffer;

    localparam int DATA_W    = 5;
    localparam int ID_W      = 3;
    localparam int DEPTH     = 4;
    localparam int RQ_DEPTH  = 2;
    localparam int RETRY_CYC = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rx_valid_i;
    logic [ID_W-1:0]   rx_id_i;
    logic [DATA_W-1:0] rx_payload_i;
    logic              rx_credit_i;
    logic              rx_ready_o;
    logic              rx_retry_o;
    logic              tx_valid_o;
    logic [ID_W-1:0]   tx_id_o;
    logic [DATA_W-1:0] tx_payload_o;
    logic              tx_ready_i;
    logic              credit_gnt_o;
    logic [ID_W-1:0]   credit_id_o;
    logic              err_o;

    credit_retry_buffer #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
        .RQ_DEPTH(RQ_DEPTH), .RETRY_CYC(RETRY_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid_i(rx_valid_i), .rx_id_i(rx_id_i), .rx_payload_i(rx_payload_i),
        .rx_credit_i(rx_credit_i), .rx_ready_o(rx_ready_o), .rx_retry_o(rx_retry_o),
        .tx_valid_o(tx_valid_o), .tx_id_o(tx_id_o), .tx_payload_o(tx_payload_o),
        .tx_ready_i(tx_ready_i), .credit_gnt_o(credit_gnt_o),
        .credit_id_o(credit_id_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] pl;
        logic              cr;
        logic              tr;
        logic              acc;
        logic              rdy;
        logic              rty;
        logic              tv;
        logic              gnt;
        logic [ID_W-1:0]   gid;
        logic              err;
    } vec_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] pl;
    } beat_t;

    vec_t  vecs[$];
    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    split;

    function automatic vec_t mk(input int v, id, pl, cr, tr, acc,
                                input int rdy, rty, tv, gnt, gid, err);
        vec_t t;
        t.v   = v[0];   t.id  = id[ID_W-1:0]; t.pl = pl[DATA_W-1:0];
        t.cr  = cr[0];  t.tr  = tr[0];        t.acc = acc[0];
        t.rdy = rdy[0]; t.rty = rty[0];       t.tv = tv[0];
        t.gnt = gnt[0]; t.gid = gid[ID_W-1:0]; t.err = err[0];
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_ready"},   32'(rx_ready_o),   32'd1);
        check({tag, " rx_retry"},   32'(rx_retry_o),   32'd0);
        check({tag, " tx_valid"},   32'(tx_valid_o),   32'd0);
        check({tag, " tx_id"},      32'(tx_id_o),      32'd0);
        check({tag, " tx_payload"}, 32'(tx_payload_o), 32'd0);
        check({tag, " credit_gnt"}, 32'(credit_gnt_o), 32'd0);
        check({tag, " credit_id"},  32'(credit_id_o),  32'd0);
        check({tag, " err"},        32'(err_o),        32'd0);
    endtask

    task automatic idle_inputs();
        rx_valid_i   = 1'b0;
        rx_id_i      = '0;
        rx_payload_i = '0;
        rx_credit_i  = 1'b0;
        tx_ready_i   = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        beat_t b;
        @(negedge clk);
        rx_valid_i   = t.v;
        rx_id_i      = t.id;
        rx_payload_i = t.pl;
        rx_credit_i  = t.cr;
        tx_ready_i   = t.tr;
        #1;
        check($sformatf("v%0d rx_ready", idx),   32'(rx_ready_o),   32'(t.rdy));
        check($sformatf("v%0d rx_retry", idx),   32'(rx_retry_o),   32'(t.rty));
        check($sformatf("v%0d tx_valid", idx),   32'(tx_valid_o),   32'(t.tv));
        check($sformatf("v%0d credit_gnt", idx), 32'(credit_gnt_o), 32'(t.gnt));
        check($sformatf("v%0d credit_id", idx),  32'(credit_id_o),  32'(t.gid));
        check($sformatf("v%0d err", idx),        32'(err_o),        32'(t.err));
        if (t.tv) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL v%0d sb_head: actual=beat required=empty", idx);
            end else begin
                check($sformatf("v%0d tx_id", idx),      32'(tx_id_o),      32'(exp_q[0].id));
                check($sformatf("v%0d tx_payload", idx), 32'(tx_payload_o), 32'(exp_q[0].pl));
            end
            if (t.tr && exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            check($sformatf("v%0d tx_id_idle", idx),      32'(tx_id_o),      32'd0);
            check($sformatf("v%0d tx_payload_idle", idx), 32'(tx_payload_o), 32'd0);
        end
        if (t.acc) begin
            b.id = t.id;
            b.pl = t.pl;
            exp_q.push_back(b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // v, id, pl, cr, tr, acc | rdy, rty, tv, gnt, gid, err
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)                      // fill FIFO with IDs 1..4
            vecs.push_back(mk(1, i, 10 + i, 0, 0, 1,  1, 0, (i > 1) ? 1 : 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 15, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 15, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 15, 0, 0, 0,  0, 1, 1, 0, 0, 0)); // third stalled cycle
        vecs.push_back(mk(1, 5, 15, 0, 0, 0,  0, 0, 1, 0, 0, 0)); // no second pulse
        vecs.push_back(mk(0, 0,  0, 0, 1, 0,  0, 0, 1, 0, 0, 0)); // pop ID 1
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 5, 0)); // grant ID 5
        vecs.push_back(mk(1, 5, 15, 1, 0, 1,  0, 0, 1, 0, 0, 0)); // credited accept
        for (int r = 6; r <= 7; r++) begin                // fill retry queue with 6, 7
            vecs.push_back(mk(1, r, 10 + r, 0, 0, 0,  0, 0, 1, 0, 0, 0));
            vecs.push_back(mk(1, r, 10 + r, 0, 0, 0,  0, 0, 1, 0, 0, 0));
            vecs.push_back(mk(1, r, 10 + r, 0, 0, 0,  0, 1, 1, 0, 0, 0));
        end
        for (int i = 0; i < 10; i++)                      // ID 0 stalls, queue full
            vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,  0, 0, 1, 0,  0, 0, 1, 0, 0, 0)); // pop ID 2
        vecs.push_back(mk(1, 0,  0, 0, 0, 0,  0, 0, 1, 1, 6, 0)); // grant 6, full before pop
        vecs.push_back(mk(1, 0,  0, 0, 0, 0,  0, 1, 1, 0, 0, 0)); // saturated stl retries at once
        vecs.push_back(mk(1, 6, 22, 1, 0, 1,  0, 0, 1, 0, 0, 0)); // credited ID 6
        vecs.push_back(mk(1, 7, 23, 1, 0, 0,  0, 0, 1, 0, 0, 0)); // credited, rsv=0
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 1, 0,  0, 0, 1, 0, 0, 1)); // pop ID 3
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 7, 1)); // grant 7 -> cnt=3, rsv=1
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1));
        split = vecs.size();
        vecs.push_back(mk(1, 3,  9, 0, 1, 1,  1, 0, 0, 0, 0, 0)); // streaming after reset
        vecs.push_back(mk(1, 4, 10, 0, 1, 1,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 11, 0, 1, 1,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 0,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0));

        idle_inputs();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < split; i++) run_vec(vecs[i], i);

        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("post_rst");

        for (int i = split; i < vecs.size(); i++) run_vec(vecs[i], i);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
